crc32_pipe: RTL and testbench
=============================

CRC32_PIPE -- requirements
Module: crc32_pipe

Interface
REQ-001 Parameter BYTES_CNT, default 15, number of bytes hashed per string.
REQ-002 Parameter BYTES_PER_STAGE, default 3, bytes folded per pipeline stage; STAGES = BYTES_CNT / BYTES_PER_STAGE.
REQ-003 Parameter POLY, default 32'h04C11DB7, generator polynomial (x^32 term implicit).
REQ-004 Parameter INIT, default 32'hFFFFFFFF, CRC seed.
REQ-005 Parameter XOR_OUT, default 32'h00000000, final XOR mask.
REQ-006 Parameter HASH_W, default 16, width of truncated Bloom address output, 1..32.
REQ-007 Parameter TAG_W, default 8, width of sideband tag carried alongside each string.
REQ-008 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-009 rst_i  input  1  synchronous, active-high reset.
REQ-010 string_i  input  [BYTES_CNT-1:0][7:0]  string to hash; byte 0 processed first.
REQ-011 tag_i  input  TAG_W  sideband tag, returned unchanged with the result.
REQ-012 valid_i  input  1  string_i/tag_i valid.
REQ-013 ready_o  output  1  block accepts a string this cycle.
REQ-014 crc_o  output  32  final CRC (after XOR_OUT).
REQ-015 hash_o  output  HASH_W  crc_o[HASH_W-1:0].
REQ-016 tag_o  output  TAG_W  tag of the string whose result is on crc_o.
REQ-017 valid_o  output  1  crc_o/hash_o/tag_o valid.
REQ-018 ready_i  input  1  downstream accepts result this cycle.

Function
REQ-019 CRC arithmetic SHALL be non-reflected, left-shifting: per byte, bits processed MSB (bit 7) first; per bit, fb = crc[31] ^ d, crc = {crc[30:0],1'b0} ^ (fb ? POLY : 0).
REQ-020 Result SHALL equal CRC over bytes 0..BYTES_CNT-1 starting from INIT, then XORed with XOR_OUT.
REQ-021 Stage k (0..STAGES-1) SHALL fold bytes k*BYTES_PER_STAGE .. (k+1)*BYTES_PER_STAGE-1 into the CRC carried from stage k-1 (stage 0 starts from INIT) and register CRC, remaining unprocessed bytes, tag and valid.
REQ-022 Input transfer SHALL occur when valid_i && ready_o; output transfer when valid_o && ready_i.
REQ-023 Pipeline advance enable SHALL be en = !valid_o || ready_i; ready_o = en; all stages advance together when en=1, hold otherwise.
REQ-024 Latency SHALL be exactly STAGES cycles from input transfer to valid_o with no backpressure; throughput one string per cycle.
REQ-025 Stage valid bit SHALL load valid_i when en=1 (bubbles propagate as invalid entries).
REQ-026 While valid_o=1 and ready_i=0, crc_o, hash_o, tag_o, valid_o SHALL stay stable.
REQ-027 Simultaneous output transfer and input transfer in one cycle SHALL lose no data and duplicate none.
REQ-028 Ordering SHALL be preserved: results leave in input acceptance order.
REQ-029 BYTES_CNT not divisible by BYTES_PER_STAGE, BYTES_PER_STAGE < 1, or HASH_W outside 1..32 SHALL be an elaboration-time error.
REQ-030 crc_o, hash_o, tag_o SHALL be driven directly from last-stage registers (no combinational path from string_i); ready_o depends combinationally only on valid_o and ready_i.

Reset
REQ-031 While rst_i=1 at a clock edge, all stage valid bits, CRC registers, byte registers and tag registers SHALL clear to 0.
REQ-032 After reset: valid_o=0, crc_o=0, hash_o=0, tag_o=0, ready_o=1.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight strings; no result of a pre-reset string SHALL appear after reset.
REQ-034 An input presented in the same cycle rst_i=1 SHALL NOT be accepted.

Verification
REQ-035 BYTES_CNT=9, BYTES_PER_STAGE=3, defaults otherwise; string "123456789" (byte0=0x31), tag 0x5A, ready_i=1 -> valid_o exactly 3 cycles later, crc_o=32'h0376E6E7, hash_o=16'hE6E7, tag_o=8'h5A.
REQ-036 Same config, XOR_OUT=32'hFFFFFFFF, same string -> crc_o=32'hFC891918.
REQ-037 Default config, 20 back-to-back random strings, ready_i=1 -> 20 results on consecutive cycles, each matching bit-serial model of REQ-019/020, tags in order.
REQ-038 Random valid_i and ready_i (50% each), 1000 strings -> no loss, no duplication, order kept, outputs stable whenever valid_o=1 and ready_i=0.
REQ-039 Fill pipeline, hold ready_i=0 -> ready_o=0 once valid_o=1; release ready_i -> results drain in order, one per cycle.
REQ-040 Pipeline holding 3 valid strings, pulse rst_i one cycle -> valid_o=0 and crc_o=0 next cycle, no stale result ever emerges, next new string produces correct CRC after STAGES cycles.

Source files
------------

// File: rtl/crc32_pipe.sv
// Pipelined non-reflected CRC-32 over a fixed-length string, BYTES_PER_STAGE bytes per stage,
// with a sideband tag and a single global valid/ready stall.
module crc32_pipe #(
    parameter int          BYTES_CNT       = 15,
    parameter int          BYTES_PER_STAGE = 3,
    parameter logic [31:0] POLY            = 32'h04C11DB7,
    parameter logic [31:0] INIT            = 32'hFFFFFFFF,
    parameter logic [31:0] XOR_OUT         = 32'h00000000,
    parameter int          HASH_W          = 16,
    parameter int          TAG_W           = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [BYTES_CNT-1:0][7:0]  string_i,
    input  logic [TAG_W-1:0]           tag_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic [31:0]                crc_o,
    output logic [HASH_W-1:0]          hash_o,
    output logic [TAG_W-1:0]           tag_o,
    output logic                       valid_o,
    input  logic                       ready_i
);

    localparam int BPS    = (BYTES_PER_STAGE < 1) ? 1 : BYTES_PER_STAGE;
    localparam int STAGES = BYTES_CNT / BPS;

    if (BYTES_PER_STAGE < 1 || (BYTES_CNT % BPS) != 0 || STAGES < 1) begin : g_bad_split
        $error("crc32_pipe: BYTES_CNT must be a positive multiple of BYTES_PER_STAGE >= 1");
    end
    if (HASH_W < 1 || HASH_W > 32) begin : g_bad_hash
        $error("crc32_pipe: HASH_W must be within 1..32");
    end

    logic en;

    function automatic logic [31:0] fold_byte(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] c;
        logic [7:0]  d;
        c = crc_in;
        d = data;
        for (int unsigned b = 0; b < 8; b++) begin
            if (c[31] ^ d[7]) c = {c[30:0], 1'b0} ^ POLY;
            else              c = {c[30:0], 1'b0};
            d = {d[6:0], 1'b0};
        end
        return c;
    endfunction

    always_comb begin
        en      = !valid_o || ready_i;
        ready_o = en;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IN_B  = BYTES_CNT - k * BPS;
        localparam int REM_B = IN_B - BPS;
        // XOR_OUT is folded into the last register so reset leaves crc_o at zero for any mask
        localparam logic [31:0] OUT_MASK = (k == STAGES - 1) ? XOR_OUT : 32'h0000_0000;

        logic [IN_B-1:0][7:0] bytes_in;
        logic [31:0]          crc_in;
        logic [31:0]          crc_nxt;
        logic [TAG_W-1:0]     tag_in;
        logic                 valid_in;
        logic [31:0]          crc_q;
        logic [TAG_W-1:0]     tag_q;
        logic                 valid_q;

        if (k == 0) begin : g_src
            always_comb begin
                bytes_in = string_i;
                crc_in   = INIT;
                tag_in   = tag_i;
                valid_in = valid_i;
            end
        end else begin : g_src
            always_comb begin
                bytes_in = g_stage[k-1].g_rem.bytes_q;
                crc_in   = g_stage[k-1].crc_q;
                tag_in   = g_stage[k-1].tag_q;
                valid_in = g_stage[k-1].valid_q;
            end
        end

        always_comb begin
            logic [IN_B-1:0][7:0] sh;
            sh      = bytes_in;
            crc_nxt = crc_in;
            for (int unsigned i = 0; i < BPS; i++) begin
                crc_nxt = fold_byte(crc_nxt, sh[0]);
                sh      = sh >> 8;
            end
            crc_nxt = crc_nxt ^ OUT_MASK;
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                crc_q   <= '0;
                tag_q   <= '0;
                valid_q <= 1'b0;
            end else if (en) begin
                crc_q   <= crc_nxt;
                tag_q   <= tag_in;
                valid_q <= valid_in;
            end
        end

        if (REM_B > 0) begin : g_rem
            logic [REM_B-1:0][7:0] bytes_q;
            always_ff @(posedge clk_i) begin
                if (rst_i)   bytes_q <= '0;
                else if (en) bytes_q <= bytes_in[IN_B-1:BPS];
            end
        end
    end

    always_comb begin
        crc_o   = g_stage[STAGES-1].crc_q;
        hash_o  = g_stage[STAGES-1].crc_q[HASH_W-1:0];
        tag_o   = g_stage[STAGES-1].tag_q;
        valid_o = g_stage[STAGES-1].valid_q;
    end

endmodule

// File: tb/tb_crc32_pipe.sv
// Directed checks of crc32_pipe: known CRC-32/MPEG-2 vectors, latency, backpressure, reset flush,
// and streamed strings against a bit-serial reference.
module tb_crc32_pipe;

    localparam logic [31:0] POLY = 32'h04C11DB7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 9-byte, 3-stage instances (plain and inverted output)
    logic [8:0][7:0] s9;
    logic [7:0]      t9;
    logic            v9, ri9;
    logic            rdy9, vo9, rdyx, vox;
    logic [31:0]     crc9, crcx;
    logic [15:0]     hash9, hashx;
    logic [7:0]      tag9, tagx;

    // default 15-byte, 5-stage instance
    logic [14:0][7:0] sd;
    logic [7:0]       td;
    logic             vd, rid;
    logic             rdyd, vod;
    logic [31:0]      crcd;
    logic [15:0]      hashd;
    logic [7:0]       tagd;

    crc32_pipe #(.BYTES_CNT(9), .BYTES_PER_STAGE(3)) dut9 (
        .clk_i(clk), .rst_i(rst), .string_i(s9), .tag_i(t9), .valid_i(v9), .ready_o(rdy9),
        .crc_o(crc9), .hash_o(hash9), .tag_o(tag9), .valid_o(vo9), .ready_i(ri9)
    );

    crc32_pipe #(.BYTES_CNT(9), .BYTES_PER_STAGE(3), .XOR_OUT(32'hFFFFFFFF)) dutx (
        .clk_i(clk), .rst_i(rst), .string_i(s9), .tag_i(t9), .valid_i(v9), .ready_o(rdyx),
        .crc_o(crcx), .hash_o(hashx), .tag_o(tagx), .valid_o(vox), .ready_i(ri9)
    );

    crc32_pipe dutd (
        .clk_i(clk), .rst_i(rst), .string_i(sd), .tag_i(td), .valid_i(vd), .ready_o(rdyd),
        .crc_o(crcd), .hash_o(hashd), .tag_o(tagd), .valid_o(vod), .ready_i(rid)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit-serial reference: byte 0 first, MSB first, left-shifting
    function automatic logic [31:0] crc_model(input logic [14:0][7:0] s, input int n,
                                              input logic [31:0] xo);
        logic [31:0] c;
        logic [7:0]  d;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            d = s[0];
            s = s >> 8;
            for (int b = 0; b < 8; b++) begin
                fb = c[31] ^ d[7];
                c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
                d  = {d[6:0], 1'b0};
            end
        end
        return c ^ xo;
    endfunction

    function automatic logic [31:0] model9(input logic [8:0][7:0] s);
        logic [14:0][7:0] w;
        w = '0;
        w[8:0] = s;
        return crc_model(w, 9, 32'h0);
    endfunction

    logic [31:0] exp9 [3];
    logic [31:0] exp_q [$];
    logic [7:0]  etag_q [$];
    logic [31:0] e_crc, hold_crc;
    logic [7:0]  e_tag, hold_tag;
    logic [15:0] hold_hash;
    logic        prev_hold;
    int          sent, got, first, last, cycles;

    initial begin
        rst = 1'b1; v9 = 1'b0; vd = 1'b0; ri9 = 1'b1; rid = 1'b1;
        s9 = '0; sd = '0; t9 = '0; td = '0;
        tick();

        // inputs offered while reset is high must be ignored
        s9 = {8'h39, 8'h38, 8'h37, 8'h36, 8'h35, 8'h34, 8'h33, 8'h32, 8'h31};
        t9 = 8'hA5; v9 = 1'b1;
        sd = 120'({$urandom(), $urandom(), $urandom(), $urandom()}); vd = 1'b1;
        tick();
        check("rst_valid", vo9, 0);
        check("rst_crc", crc9, 0);
        check("rst_hash", hash9, 0);
        check("rst_tag", tag9, 0);
        check("rst_ready", rdy9, 1);
        check("rst_crc_xor", crcx, 0);
        check("rst_valid_def", vod, 0);
        check("rst_ready_def", rdyd, 1);
        rst = 1'b0; v9 = 1'b0; vd = 1'b0;
        repeat (6) begin
            tick();
            check("no_accept_in_rst9", vo9, 0);
            check("no_accept_in_rstd", vod, 0);
        end

        // "123456789": latency and known CRCs
        t9 = 8'h5A; v9 = 1'b1;
        tick(); v9 = 1'b0;
        check("lat_c1", vo9, 0);
        tick();
        check("lat_c2", vo9, 0);
        tick();
        check("lat_c3_valid", vo9, 1);
        check("check_crc", crc9, 32'h0376E6E7);
        check("check_hash", hash9, 16'hE6E7);
        check("check_tag", tag9, 8'h5A);
        check("xor_valid", vox, 1);
        check("xor_crc", crcx, 32'hFC891918);
        check("xor_tag", tagx, 8'h5A);
        tick();
        check("single_pulse", vo9, 0);

        // backpressure: fill, hold, then drain in order
        ri9 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s9 = 72'({$urandom(), $urandom(), $urandom()});
            exp9[k] = model9(s9);
            t9 = 8'(k + 1); v9 = 1'b1;
            tick();
        end
        s9 = 72'({$urandom(), $urandom(), $urandom()});
        t9 = 8'hEE;
        check("bp_valid", vo9, 1);
        check("bp_ready_low", rdy9, 0);
        repeat (3) begin
            tick();
            check("bp_hold_valid", vo9, 1);
            check("bp_hold_crc", crc9, exp9[0]);
            check("bp_hold_tag", tag9, 1);
            check("bp_hold_ready", rdy9, 0);
        end
        v9 = 1'b0; ri9 = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("drain_valid", vo9, 1);
            check("drain_crc", crc9, exp9[k]);
            check("drain_tag", tag9, 8'(k + 1));
            tick();
        end
        check("drain_empty", vo9, 0);

        // reset with three strings in flight
        for (int k = 0; k < 3; k++) begin
            s9 = 72'({$urandom(), $urandom(), $urandom()});
            t9 = 8'(8'h10 + k); v9 = 1'b1;
            tick();
        end
        v9 = 1'b0;
        check("flush_pre_valid", vo9, 1);
        rst = 1'b1;
        tick();
        check("flush_valid", vo9, 0);
        check("flush_crc", crc9, 0);
        check("flush_tag", tag9, 0);
        rst = 1'b0;
        repeat (5) begin
            tick();
            check("flush_no_stale", vo9, 0);
        end
        s9 = {8'h39, 8'h38, 8'h37, 8'h36, 8'h35, 8'h34, 8'h33, 8'h32, 8'h31};
        t9 = 8'h77; v9 = 1'b1;
        tick(); v9 = 1'b0;
        tick(); tick();
        check("post_flush_valid", vo9, 1);
        check("post_flush_crc", crc9, 32'h0376E6E7);
        check("post_flush_tag", tag9, 8'h77);

        // 20 back-to-back strings on the default instance
        rid = 1'b1; sent = 0; got = 0; first = -1; last = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (vod) begin
                if (exp_q.size() == 0) check("b2b_extra", 1, 0);
                else begin
                    e_crc = exp_q.pop_front();
                    e_tag = etag_q.pop_front();
                    check("b2b_crc", crcd, e_crc);
                    check("b2b_tag", tagd, e_tag);
                end
                got++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (sent < 20) begin
                sd = 120'({$urandom(), $urandom(), $urandom(), $urandom()});
                td = sent[7:0]; vd = 1'b1;
                if (rdyd) begin
                    exp_q.push_back(crc_model(sd, 15, 32'h0));
                    etag_q.push_back(td);
                    sent++;
                end
            end else vd = 1'b0;
            tick();
        end
        check("b2b_count", got, 20);
        check("b2b_first", first, 5);
        check("b2b_consecutive", last - first, 19);

        // random valid/ready traffic
        sent = 0; got = 0; cycles = 0; prev_hold = 1'b0;
        exp_q.delete(); etag_q.delete();
        vd = 1'b0;
        while (got < 1000 && cycles < 20000) begin
            if (prev_hold) begin
                check("stall_valid", vod, 1);
                check("stall_crc", crcd, hold_crc);
                check("stall_hash", hashd, hold_hash);
                check("stall_tag", tagd, hold_tag);
            end
            rid = 1'($urandom_range(0, 1));
            if (sent < 1000 && $urandom_range(0, 1) == 1) begin
                sd = 120'({$urandom(), $urandom(), $urandom(), $urandom()});
                td = sent[7:0]; vd = 1'b1;
            end else vd = 1'b0;
            #1;
            check("rnd_ready", rdyd, !vod || rid);
            if (vod && rid) begin
                if (exp_q.size() == 0) check("rnd_extra", 1, 0);
                else begin
                    e_crc = exp_q.pop_front();
                    e_tag = etag_q.pop_front();
                    check("rnd_crc", crcd, e_crc);
                    check("rnd_hash", hashd, e_crc[15:0]);
                    check("rnd_tag", tagd, e_tag);
                end
                got++;
            end
            prev_hold = vod && !rid;
            hold_crc = crcd; hold_hash = hashd; hold_tag = tagd;
            if (vd && (!vod || rid)) begin
                exp_q.push_back(crc_model(sd, 15, 32'h0));
                etag_q.push_back(td);
                sent++;
            end
            tick();
            cycles++;
        end
        check("rnd_received", got, 1000);
        check("rnd_sent", sent, 1000);
        check("rnd_leftover", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
